// File: rtl/first_nios2_system_sysid_bank.sv
// System ID / uptime / seconds / scratch register bank on an Avalon-MM slave.
// All reads return one cycle after the command, with zero-filled data when idle.
module first_nios2_system_sysid_bank #(
  parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  parameter int          NUM_SCRATCH   = 2,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
  parameter int          ADDR_W        = 4,
  // Uptime value loaded by reset; nonzero only to reach the high-word carry quickly in simulation.
  parameter logic [63:0] UPTIME_INIT   = 64'h0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [ADDR_W-1:0] ADDR_ID        = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_TIMESTAMP = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_UP_LO     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_UP_HI     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_SECONDS   = ADDR_W'(4);
  localparam int                SCRATCH_BASE   = 5;
  localparam logic [31:0]       PRESCALE_LAST  = 32'(CLK_FREQ_HZ - 1);

  logic [63:0] uptime;
  logic [31:0] uptime_hi_shadow;
  logic [31:0] prescaler;
  logic [31:0] seconds;
  logic [31:0] scratch [NUM_SCRATCH];
  logic [31:0] read_mux;

  logic up_lo_read;
  logic seconds_clear;

  assign up_lo_read    = read && (address == ADDR_UP_LO);
  assign seconds_clear = write && (address == ADDR_SECONDS);

  always_comb begin
    read_mux = 32'h0;
    if (address == ADDR_ID)             read_mux = ID_VALUE;
    else if (address == ADDR_TIMESTAMP) read_mux = TIMESTAMP;
    else if (address == ADDR_UP_LO)     read_mux = uptime[31:0];
    else if (address == ADDR_UP_HI)     read_mux = uptime_hi_shadow;
    else if (address == ADDR_SECONDS)   read_mux = seconds;
    else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (address == ADDR_W'(SCRATCH_BASE + i)) read_mux = scratch[i];
      end
    end
  end

  // The shadow captures the high word from the same sample as the low word being returned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime           <= UPTIME_INIT;
      uptime_hi_shadow <= 32'h0;
    end else begin
      uptime <= uptime + 64'd1;
      if (up_lo_read) uptime_hi_shadow <= uptime[63:32];
    end
  end

  // A SECONDS write wins over a coincident terminal count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= 32'h0;
      seconds   <= 32'h0;
    end else if (seconds_clear) begin
      prescaler <= 32'h0;
      seconds   <= 32'h0;
    end else if (prescaler == PRESCALE_LAST) begin
      prescaler <= 32'h0;
      seconds   <= seconds + 32'd1;
    end else begin
      prescaler <= prescaler + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= SCRATCH_RESET;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (write && (address == ADDR_W'(SCRATCH_BASE + i))) begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) scratch[i][8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      readdata      <= read ? read_mux : 32'h0;
    end
  end

endmodule
